// File: rtl/light_show_pkg.sv
// Shared types, widths and pattern helpers for the rotating light show.
package light_show_pkg;

   localparam int unsigned LED_W = 16;
   localparam int unsigned SW_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // switch+1 ones packed into the LSBs
   function automatic logic [LED_W-1:0] pattern_from_switch(input logic [SW_W-1:0] sw);
      logic [LED_W-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < LED_W; i++) begin
         p[i] = (i <= 32'(sw));
      end
      return p;
   endfunction

   // dir=0 moves bits toward the MSB, dir=1 toward the LSB
   function automatic logic [LED_W-1:0] rotate_step(input logic [LED_W-1:0] v, input logic d);
      return d ? {v[0], v[LED_W-1:1]} : {v[LED_W-2:0], v[LED_W-1]};
   endfunction

endpackage

// File: rtl/light_tick_gen.sv
// Rotation-step timer: counts 0..TICK_DIV-1 while enabled, pulses tick_c on the last count.
module light_tick_gen #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/light_show_ctrl.sv
// Rotating LED light show with start/pause/resume button and switch-selected lit count.
// Optional button debounce is compiled in with LIGHT_SHOW_DEBOUNCE_EN.
module light_show_ctrl
   import light_show_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 100000000,
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic [SW_W-1:0]  switch,
   input  logic             dir,
   output logic [LED_W-1:0] led,
   output logic             busy
);

   if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
      $error("light_show_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
   end

   state_t          state;
   logic [1:0]      btn_sync;
   logic [1:0]      dir_sync;
   logic [SW_W-1:0] sw_sync1;
   logic [SW_W-1:0] switch_s;
   logic [SW_W-1:0] sw_cur;
   logic            btn_q;
   logic            btn_prev;
   logic            press;
   logic            sw_chg;
   logic            tick_c;

   // Two-flop synchronizers plus the previous-button flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_sync <= '0;
         dir_sync <= '0;
         sw_sync1 <= '0;
         switch_s <= '0;
         btn_prev <= 1'b0;
      end else begin
         btn_sync <= {btn_sync[0], button};
         dir_sync <= {dir_sync[0], dir};
         sw_sync1 <= switch;
         switch_s <= sw_sync1;
         btn_prev <= btn_q;
      end
   end

`ifdef LIGHT_SHOW_DEBOUNCE_EN
   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   logic [DEB_W-1:0] deb_cnt;

   // Accept a new level only after DEB_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_cnt <= '0;
         btn_q   <= 1'b0;
      end else if (btn_sync[1] == btn_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
         deb_cnt <= '0;
         btn_q   <= btn_sync[1];
      end else begin
         deb_cnt <= deb_cnt + DEB_W'(1);
      end
   end
`else
   assign btn_q = btn_sync[1];
`endif

   assign press  = btn_q & ~btn_prev;
   assign sw_chg = (switch_s != sw_cur);

   light_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == LOAD),
      .en     (state == RUN),
      .tick_c (tick_c)
   );

   // Switch changes reload the pattern and win over a same-cycle press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         led    <= '0;
         busy   <= 1'b0;
         sw_cur <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (press) begin
                  state  <= LOAD;
                  busy   <= 1'b1;
                  led    <= pattern_from_switch(switch_s);
                  sw_cur <= switch_s;
               end
            end
            LOAD: state <= RUN;
            RUN: begin
               if (sw_chg) begin
                  state  <= LOAD;
                  led    <= pattern_from_switch(switch_s);
                  sw_cur <= switch_s;
               end else begin
                  if (tick_c) led <= rotate_step(led, dir_sync[1]);
                  if (press) state <= HOLD;
               end
            end
            HOLD: begin
               if (sw_chg) begin
                  state  <= LOAD;
                  led    <= pattern_from_switch(switch_s);
                  sw_cur <= switch_s;
               end else if (press) begin
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
